// File: rtl/product_accumulator_if.sv
// product_accumulator_if: job control, product and result handshake bundle for product_accumulator
interface product_accumulator_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int GUARD_BITS  = 4,
  parameter int COUNT_WIDTH = 8
);
  localparam int ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS;
  logic                    clear_i;
  logic                    start_i;
  logic [COUNT_WIDTH-1:0]  num_terms_i;
  logic [2*DATA_WIDTH-1:0] product_i;
  logic                    valid_i;
  logic                    ready_o;
  logic [ACC_WIDTH-1:0]    result_o;
  logic                    result_valid_o;
  logic                    result_ready_i;
  logic                    overflow_o;
  logic                    busy_o;
  modport master (
    output clear_i, start_i, num_terms_i, product_i, valid_i, result_ready_i,
    input  ready_o, result_o, result_valid_o, overflow_o, busy_o
  );
  modport slave (
    input  clear_i, start_i, num_terms_i, product_i, valid_i, result_ready_i,
    output ready_o, result_o, result_valid_o, overflow_o, busy_o
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums a counted job of unsigned products; PRODUCT_ACCUMULATOR_SATURATION_EN clamps on overflow instead of wrapping
module product_accumulator #(
  parameter int DATA_WIDTH  = 8,
  parameter int GUARD_BITS  = 4,
  parameter int COUNT_WIDTH = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  product_accumulator_if.slave bus
);
  localparam int ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS;
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ACCUMULATE = 2'd1;
  localparam logic [1:0] DONE       = 2'd2;
  logic [1:0]             state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   acc_add;
  logic [ACC_WIDTH:0]     sum;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   ovf;
  // carry out of the full-width add flags overflow; saturating builds pin the sum at all-ones once it has overflowed
  always_comb begin
    sum = {1'b0, acc} + {{(GUARD_BITS+1){1'b0}}, bus.product_i};
`ifdef PRODUCT_ACCUMULATOR_SATURATION_EN
    acc_add = (sum[ACC_WIDTH] || ovf) ? '1 : sum[ACC_WIDTH-1:0];
`else
    acc_add = sum[ACC_WIDTH-1:0];
`endif
  end
  // job FSM; clear wins over start and both handshakes, and a product offered alongside it is dropped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (bus.clear_i) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start_i) begin
        state <= (bus.num_terms_i != '0) ? ACCUMULATE : DONE;
        acc   <= '0;
        cnt   <= bus.num_terms_i;
        ovf   <= 1'b0;
      end
    end else if (state == ACCUMULATE) begin
      if (bus.valid_i) begin
        state <= (cnt == COUNT_WIDTH'(1)) ? DONE : ACCUMULATE;
        acc   <= acc_add;
        cnt   <= cnt - COUNT_WIDTH'(1);
        ovf   <= ovf | sum[ACC_WIDTH];
      end
    end else if (state == DONE) begin
      if (bus.result_ready_i) state <= IDLE;
    end else begin
      state <= IDLE;
    end
  end
  assign bus.ready_o        = (state == ACCUMULATE);
  assign bus.result_valid_o = (state == DONE);
  assign bus.busy_o         = (state != IDLE);
  assign bus.result_o       = acc;
  assign bus.overflow_o     = ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed jobs checked every cycle against an unbounded-sum job model plus literal expectations
module tb_product_accumulator;
  localparam int ACC_W = 20;
  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 1;
  logic clk_i = 1'b0;
  logic rst_i;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  product_accumulator_if #(.DATA_WIDTH(8), .GUARD_BITS(4), .COUNT_WIDTH(8)) bus ();
  product_accumulator #(.DATA_WIDTH(8), .GUARD_BITS(4), .COUNT_WIDTH(8)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  // job model: phase 0 idle, 1 collecting, 2 result offered; sum is the exact mathematical total
  int m_phase;
  int m_left;
  longint unsigned m_sum;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i || bus.clear_i) begin
      m_phase <= 0;
      m_left  <= 0;
      m_sum   <= 0;
    end else if (m_phase == 0) begin
      if (bus.start_i) begin
        m_sum   <= 0;
        m_left  <= int'(bus.num_terms_i);
        m_phase <= (bus.num_terms_i == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (bus.valid_i) begin
        m_sum   <= m_sum + longint'(bus.product_i);
        m_left  <= m_left - 1;
        m_phase <= (m_left == 1) ? 2 : 1;
      end
    end else if (bus.result_ready_i) begin
      m_phase <= 0;
    end
  end
  function automatic logic [31:0] exp_result();
`ifdef PRODUCT_ACCUMULATOR_SATURATION_EN
    return (m_sum > ACC_MAX) ? 32'(ACC_MAX) : 32'(m_sum % (ACC_MAX + 1));
`else
    return 32'(m_sum % (ACC_MAX + 1));
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("model_ready", 32'(bus.ready_o), 32'(m_phase == 1));
      chk("model_result_valid", 32'(bus.result_valid_o), 32'(m_phase == 2));
      chk("model_busy", 32'(bus.busy_o), 32'(m_phase != 0));
      chk("model_result", 32'(bus.result_o), exp_result());
      chk("model_overflow", 32'(bus.overflow_o), 32'(m_sum > ACC_MAX));
    end
  end
  task automatic cyc();
    @(negedge clk_i);
  endtask
  task automatic start_job(input int n);
    bus.start_i = 1'b1;
    bus.num_terms_i = 8'(n);
    cyc();
    bus.start_i = 1'b0;
  endtask
  task automatic feed(input logic [15:0] p);
    bus.product_i = p;
    bus.valid_i = 1'b1;
    cyc();
    bus.valid_i = 1'b0;
  endtask
  task automatic take_result();
    bus.result_ready_i = 1'b1;
    cyc();
    bus.result_ready_i = 1'b0;
  endtask
  initial begin
    rst_i = 1'b1;
    bus.clear_i = 1'b0;
    bus.start_i = 1'b0;
    bus.num_terms_i = '0;
    bus.product_i = '0;
    bus.valid_i = 1'b0;
    bus.result_ready_i = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b1;
    chk("reset_busy", 32'(bus.busy_o), 32'd0);
    chk("reset_result", 32'(bus.result_o), 32'd0);
    chk("reset_result_valid", 32'(bus.result_valid_o), 32'd0);
    rst_i = 1'b0;
    cyc();
    // three back-to-back products
    start_job(3);
    feed(16'h0010);
    feed(16'h0020);
    feed(16'h0030);
    chk("basic_valid_latency", 32'(bus.result_valid_o), 32'd1);
    chk("basic_sum", 32'(bus.result_o), 32'h00060);
    chk("basic_ovf", 32'(bus.overflow_o), 32'd0);
    take_result();
    chk("basic_idle", 32'(bus.busy_o), 32'd0);
    // gapped valid, a stray start mid-job, and a stalled result
    start_job(3);
    feed(16'h0010);
    bus.start_i = 1'b1;
    bus.num_terms_i = 8'd2;
    cyc();
    bus.start_i = 1'b0;
    feed(16'h0020);
    cyc();
    feed(16'h0030);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(bus.result_valid_o), 32'd1);
      chk("stall_sum", 32'(bus.result_o), 32'h00060);
      cyc();
    end
    take_result();
    // 16 and 17 terms of 0xFE01 straddle the 20-bit limit
    start_job(16);
    for (int i = 0; i < 16; i++) feed(16'hFE01);
    chk("t16_sum", 32'(bus.result_o), 32'h0FE010);
    chk("t16_ovf", 32'(bus.overflow_o), 32'd0);
    take_result();
    start_job(17);
    for (int i = 0; i < 17; i++) feed(16'hFE01);
`ifdef PRODUCT_ACCUMULATOR_SATURATION_EN
    chk("t17_sum", 32'(bus.result_o), 32'h0FFFFF);
`else
    chk("t17_sum", 32'(bus.result_o), 32'h00DE11);
`endif
    chk("t17_ovf", 32'(bus.overflow_o), 32'd1);
    take_result();
    // zero-term job goes straight to DONE and accepts nothing
    bus.product_i = 16'h0055;
    bus.valid_i = 1'b1;
    start_job(0);
    chk("zero_done", 32'(bus.result_valid_o), 32'd1);
    chk("zero_ready", 32'(bus.ready_o), 32'd0);
    chk("zero_sum", 32'(bus.result_o), 32'd0);
    take_result();
    bus.valid_i = 1'b0;
    chk("zero_sum_after", 32'(bus.result_o), 32'd0);
    // clear after two of five transfers, with a product offered in the same cycle
    start_job(5);
    feed(16'h0003);
    feed(16'h0004);
    bus.clear_i = 1'b1;
    bus.start_i = 1'b1;
    bus.num_terms_i = 8'd2;
    feed(16'h0007);
    bus.clear_i = 1'b0;
    bus.start_i = 1'b0;
    chk("clear_ready", 32'(bus.ready_o), 32'd0);
    chk("clear_sum", 32'(bus.result_o), 32'd0);
    chk("clear_busy", 32'(bus.busy_o), 32'd0);
    start_job(1);
    feed(16'h0005);
    chk("after_clear_sum", 32'(bus.result_o), 32'h00005);
    take_result();
    // asynchronous reset between edges mid-job
    start_job(5);
    feed(16'h0009);
    #2;
    rst_i = 1'b1;
    bus.start_i = 1'b1;
    bus.num_terms_i = 8'd1;
    #1;
    chk("async_busy", 32'(bus.busy_o), 32'd0);
    chk("async_ready", 32'(bus.ready_o), 32'd0);
    chk("async_sum", 32'(bus.result_o), 32'd0);
    chk("async_valid", 32'(bus.result_valid_o), 32'd0);
    cyc();
    chk("rst_start_ignored", 32'(bus.busy_o), 32'd0);
    bus.start_i = 1'b0;
    rst_i = 1'b0;
    cyc();
    start_job(1);
    feed(16'h0007);
    chk("post_rst_sum", 32'(bus.result_o), 32'h00007);
    take_result();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand width of the upstream multiplier; product width is 2*DATA_WIDTH.
REQ-002 SHALL have parameter GUARD_BITS, default 4: extra accumulator MSBs; ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS.
REQ-003 SHALL have parameter COUNT_WIDTH, default 8: width of the term-count input.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk_i input 1 (rising-edge clock); rst_i input 1 (async reset, active-high).
REQ-005 clear_i input 1: synchronous abort, returns the block to IDLE.
REQ-006 start_i input 1: begins an accumulation job.
REQ-007 num_terms_i input COUNT_WIDTH: number of products in the job, sampled on the start cycle.
REQ-008 product_i input 2*DATA_WIDTH: unsigned product from the combinational multiplier.
REQ-009 valid_i input 1 / ready_o output 1: product handshake; a transfer occurs when both are high on a rising edge.
REQ-010 result_o output ACC_WIDTH: accumulated sum.
REQ-011 result_valid_o output 1 / result_ready_i input 1: result handshake.
REQ-012 overflow_o output 1: sticky per job; set when any addition exceeds ACC_WIDTH bits.
REQ-013 busy_o output 1: high in every state except IDLE.

Function
REQ-014 FSM SHALL have states IDLE, ACCUMULATE, DONE.
REQ-015 IDLE: on start_i with num_terms_i != 0, SHALL zero the accumulator and overflow flag, load the counter with num_terms_i, and go to ACCUMULATE.
REQ-016 IDLE: on start_i with num_terms_i == 0, SHALL zero the accumulator and go directly to DONE (result 0, overflow 0).
REQ-017 ready_o SHALL be high only in ACCUMULATE, decoded from the state register alone with no combinational path from valid_i.
REQ-018 Each transfer SHALL add zero-extended product_i to the accumulator and decrement the counter; cycles with valid_i low SHALL leave the accumulator and counter unchanged.
REQ-019 The transfer that brings the counter to 0 SHALL move the FSM to DONE; result_valid_o SHALL go high on the next cycle (1-cycle latency after the last transfer).
REQ-020 DONE: result_o and overflow_o SHALL hold stable while result_valid_o is high; on result_valid_o & result_ready_i the FSM SHALL go to IDLE.
REQ-021 start_i SHALL be ignored outside IDLE; a back-to-back start is accepted no earlier than the cycle after the DONE handshake.
REQ-022 clear_i SHALL take priority over start_i and handshakes in every state: next state IDLE, accumulator 0, counter 0, overflow 0; a product presented in the same cycle is dropped.
REQ-023 Unsigned arithmetic only; overflow detection SHALL use the carry out of the ACC_WIDTH-bit addition.
REQ-024 result_o SHALL show the running sum in all states; only result_valid_o qualifies it.

Reset
REQ-025 rst_i assertion SHALL immediately force state IDLE, accumulator 0, counter 0, overflow_o 0, ready_o 0, result_valid_o 0, busy_o 0, independent of clk_i.
REQ-026 Reset mid-job SHALL discard the job; the first start_i after deassertion SHALL behave as from power-up.

Configuration
REQ-027 Macro PRODUCT_ACCUMULATOR_SATURATION_EN selects overflow handling.
REQ-028 With the macro defined, an overflowing addition SHALL clamp the accumulator to all-ones and hold it there for the rest of the job; overflow_o is set.
REQ-029 With the macro undefined, the accumulator SHALL wrap modulo 2^ACC_WIDTH; overflow_o is still set.

Verification (DATA_WIDTH=8, GUARD_BITS=4, ACC_WIDTH=20)
REQ-030 start, num_terms=3, products 0x0010,0x0020,0x0030 with valid_i always high -> result_o=0x00060, result_valid_o high 1 cycle after the 3rd transfer, overflow_o=0.
REQ-031 Same job with valid_i toggled 1-0-1-0-1 and result_ready_i held low for 4 cycles -> same sum 0x00060; result_o stable and result_valid_o high until result_ready_i is asserted.
REQ-032 17 terms of 0xFE01 -> with macro: result_o=0xFFFFF, overflow_o=1; without macro: result_o=0x0DE11, overflow_o=1; 16 terms -> 0xFE010, overflow_o=0.
REQ-033 start with num_terms=0 -> DONE on the next cycle, result_o=0, no product transfers accepted.
REQ-034 clear_i asserted after 2 of 5 transfers -> IDLE the next cycle, result_o=0, ready_o=0; a following 1-term job of 0x0005 -> result_o=0x00005.
REQ-035 rst_i pulsed asynchronously between clock edges during ACCUMULATE -> all outputs 0 before the next edge; start_i ignored while rst_i is high.
